// File: rtl/tx_fc_pkg.sv
// tx_fc_pkg: shared definitions for the SpaceWire TX flow-control credit logic.
//   tx_credit_state_t  : credit counter FSM states
//   TX_*_DEF           : default counter width, per-FCT increment and credit ceiling
package tx_fc_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        RUN      = 2'd1,
        ERROR    = 2'd2
    } tx_credit_state_t;

    localparam int TX_CREDIT_W_DEF   = 6;
    localparam int TX_FCT_INC_DEF    = 8;
    localparam int TX_MAX_CREDIT_DEF = 56;

endpackage

// File: rtl/tx_fc_edge_det.sv
// tx_fc_edge_det: 1-bit rising-edge detector.
// Ports:
//   clk  in   clock
//   rst  in   asynchronous active-high reset
//   din  in   level input
//   rise out  din high this cycle and low the previous cycle
module tx_fc_edge_det
    import tx_fc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/tx_credit_counter.sv
// tx_credit_counter: SpaceWire TX flow-control credit counter.
// Adds FCT_INC credits per received FCT, consumes one per N-Char sent and
// flags credit overflow.
// Optional feature macro: TX_CREDIT_ERROR_EN
//   defined   : overflow enters ERROR, freezes the count and sets sticky credit_error
//   undefined : overflow saturates the count at MAX_CREDIT, credit_error tied low
// Ports:
//   pclk_tx        in   TX clock
//   reset_tx       in   asynchronous active-high reset
//   enable_tx      in   link enable; low clears credit and holds the block idle
//   gotfct_tx      in   FCT received (level, one FCT per rising edge)
//   char_sent      in   N-Char sent (level, one credit per rising edge)
//   fct_counter_p  out  current credit
//   credit_avail   out  credit is non-zero
//   credit_full    out  a further FCT would exceed MAX_CREDIT
//   credit_error   out  sticky credit overflow error
module tx_credit_counter
    import tx_fc_pkg::*;
#(
    parameter int CREDIT_W   = TX_CREDIT_W_DEF,
    parameter int FCT_INC    = TX_FCT_INC_DEF,
    parameter int MAX_CREDIT = TX_MAX_CREDIT_DEF
) (
    input  logic                pclk_tx,
    input  logic                reset_tx,
    input  logic                enable_tx,
    input  logic                gotfct_tx,
    input  logic                char_sent,
    output logic [CREDIT_W-1:0] fct_counter_p,
    output logic                credit_avail,
    output logic                credit_full,
    output logic                credit_error
);

    if (CREDIT_W < 1 || MAX_CREDIT >= (1 << CREDIT_W) || FCT_INC < 1 || FCT_INC > MAX_CREDIT) begin : g_bad_params
        $error("tx_credit_counter: illegal CREDIT_W/FCT_INC/MAX_CREDIT combination");
    end

    localparam int XW = CREDIT_W + 1;
    localparam logic [CREDIT_W:0]   INC_X = XW'(FCT_INC);
    localparam logic [CREDIT_W:0]   MAX_X = XW'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDIT);

    tx_credit_state_t  state;
    logic              inc;
    logic              dec;
    logic [CREDIT_W:0] cnt_x;
    logic [CREDIT_W:0] sum;
    logic              overflow;

    tx_fc_edge_det u_fct_edge (
        .clk  (pclk_tx),
        .rst  (reset_tx),
        .din  (gotfct_tx),
        .rise (inc)
    );

    tx_fc_edge_det u_char_edge (
        .clk  (pclk_tx),
        .rst  (reset_tx),
        .din  (char_sent),
        .rise (dec)
    );

    function automatic logic full_of(input logic [CREDIT_W:0] v);
        return (v + INC_X) > MAX_X;
    endfunction

    // One-bit-wider update so an overflowing sum is visible before it is committed.
    always_comb begin
        cnt_x = {1'b0, fct_counter_p};
        sum   = cnt_x;
        case ({inc, dec})
            2'b10:   sum = cnt_x + INC_X;
            2'b01:   sum = (cnt_x != '0) ? cnt_x - XW'(1) : cnt_x;
            // A consume with no credit is dropped, so the FCT lands in full.
            2'b11:   sum = (cnt_x != '0) ? cnt_x + INC_X - XW'(1) : INC_X;
            default: sum = cnt_x;
        endcase
        overflow = sum > MAX_X;
    end

    always_ff @(posedge pclk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            state         <= DISABLED;
            fct_counter_p <= '0;
            credit_avail  <= 1'b0;
            credit_full   <= 1'b0;
`ifdef TX_CREDIT_ERROR_EN
            credit_error  <= 1'b0;
`endif
        end else if (!enable_tx) begin
            state         <= DISABLED;
            fct_counter_p <= '0;
            credit_avail  <= 1'b0;
            credit_full   <= 1'b0;
`ifdef TX_CREDIT_ERROR_EN
            credit_error  <= 1'b0;
`endif
        end else begin
            case (state)
                DISABLED: begin
                    state <= RUN;
                end
                RUN: begin
                    if (overflow) begin
`ifdef TX_CREDIT_ERROR_EN
                        state        <= ERROR;
                        credit_error <= 1'b1;
`else
                        fct_counter_p <= MAX_C;
                        credit_avail  <= 1'b1;
                        credit_full   <= full_of({1'b0, MAX_C});
`endif
                    end else begin
                        fct_counter_p <= sum[CREDIT_W-1:0];
                        credit_avail  <= sum != '0;
                        credit_full   <= full_of(sum);
                    end
                end
`ifdef TX_CREDIT_ERROR_EN
                ERROR: begin
                    state <= ERROR;
                end
`endif
                default: begin
                    state <= DISABLED;
                end
            endcase
        end
    end

`ifndef TX_CREDIT_ERROR_EN
    assign credit_error = 1'b0;
`endif

endmodule

// File: tb/tb_tx_credit_counter.sv
module tb_tx_credit_counter;

`ifdef TX_CREDIT_ERROR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en1, g1, c1;
    logic       en2, g2, c2;
    logic [5:0] cnt1;
    logic [7:0] cnt2;
    logic       avail1, full1, err1;
    logic       avail2, full2, err2;

    always #5 clk = ~clk;

    tx_credit_counter dut (
        .pclk_tx       (clk),
        .reset_tx      (rst),
        .enable_tx     (en1),
        .gotfct_tx     (g1),
        .char_sent     (c1),
        .fct_counter_p (cnt1),
        .credit_avail  (avail1),
        .credit_full   (full1),
        .credit_error  (err1)
    );

    tx_credit_counter #(
        .CREDIT_W   (8),
        .FCT_INC    (8),
        .MAX_CREDIT (248)
    ) dut2 (
        .pclk_tx       (clk),
        .reset_tx      (rst),
        .enable_tx     (en2),
        .gotfct_tx     (g2),
        .char_sent     (c2),
        .fct_counter_p (cnt2),
        .credit_avail  (avail2),
        .credit_full   (full2),
        .credit_error  (err2)
    );

    typedef struct {
        bit g;
        bit c;
        bit en;
        int cnt;
        bit err;
    } vec_t;

    typedef struct {
        int cnt;
        bit avail;
        bit full;
        bit err;
        int idx;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic void add(input bit g, input bit c, input bit en, input int cnt, input bit err);
        vec_t v;
        v.g = g; v.c = c; v.en = en; v.cnt = cnt; v.err = err;
        tbl.push_back(v);
    endfunction

    task automatic check_outputs(input int unit, input exp_t e, input string tag);
        if (unit == 0) begin
            chk({tag, " count"}, int'(cnt1), e.cnt);
            chk({tag, " avail"}, int'(avail1), int'(e.avail));
            chk({tag, " full"},  int'(full1),  int'(e.full));
            chk({tag, " error"}, int'(err1),   int'(e.err));
        end else begin
            chk({tag, " count"}, int'(cnt2), e.cnt);
            chk({tag, " avail"}, int'(avail2), int'(e.avail));
            chk({tag, " full"},  int'(full2),  int'(e.full));
            chk({tag, " error"}, int'(err2),   int'(e.err));
        end
    endtask

    // Drive one vector at the falling edge, push its expectation, then
    // pop and compare just after the next rising edge.
    task automatic run_vec(input int unit, input vec_t v, input int idx);
        exp_t e;
        int   ceiling;
        @(negedge clk);
        if (unit == 0) begin
            g1 = v.g; c1 = v.c; en1 = v.en;
        end else begin
            g2 = v.g; c2 = v.c; en2 = v.en;
        end
        ceiling = (unit == 0) ? 56 : 248;
        e.cnt   = v.cnt;
        e.avail = (v.cnt != 0);
        e.full  = (v.cnt + 8 > ceiling);
        e.err   = v.err;
        e.idx   = idx;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_outputs(unit, e, $sformatf("u%0d v%0d", unit, e.idx));
    endtask

    task automatic run_table(input int unit);
        for (int i = 0; i < tbl.size(); i++) run_vec(unit, tbl[i], i);
    endtask

    initial begin
        exp_t z;
        int   n;
        z.cnt = 0; z.avail = 1'b0; z.full = 1'b0; z.err = 1'b0; z.idx = 0;

        rst = 1'b1;
        en1 = 1'b0; g1 = 1'b0; c1 = 1'b0;
        en2 = 1'b0; g2 = 1'b0; c2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs(0, z, "reset");
        check_outputs(1, z, "reset2");
        @(negedge clk);
        rst = 1'b0;

        // Default instance: ramp, overflow, drain, simultaneous edges,
        // held level, enable drop and the full boundary.
        add(0, 0, 1, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            add(1, 0, 1, 8 * k, 0);
            add(0, 0, 1, 8 * k, 0);
        end
        add(1, 0, 1, 56, ERR_EN);
        add(0, 0, 1, 56, ERR_EN);
        add(0, 1, 1, ERR_EN ? 56 : 55, ERR_EN);
        add(0, 0, 1, ERR_EN ? 56 : 55, ERR_EN);
        add(0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0);
        add(1, 0, 1, 8, 0);
        add(0, 0, 1, 8, 0);
        for (int k = 1; k <= 9; k++) begin
            n = (k <= 8) ? 8 - k : 0;
            add(0, 1, 1, n, 0);
            add(0, 0, 1, n, 0);
        end
        add(1, 1, 1, 8, 0);
        add(0, 0, 1, 8, 0);
        add(1, 0, 1, 16, 0);
        add(0, 0, 1, 16, 0);
        add(1, 1, 1, 23, 0);
        add(0, 0, 1, 23, 0);
        for (int k = 1; k <= 7; k++) begin
            add(0, 1, 1, 23 - k, 0);
            add(0, 0, 1, 23 - k, 0);
        end
        for (int k = 0; k < 10; k++) add(1, 0, 1, 24, 0);
        add(0, 0, 1, 24, 0);
        add(1, 0, 1, 32, 0);
        add(0, 0, 1, 32, 0);
        add(1, 0, 1, 40, 0);
        add(0, 0, 1, 40, 0);
        add(0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            add(1, 0, 1, 8 * k, 0);
            add(0, 0, 1, 8 * k, 0);
        end
        add(1, 1, 1, 55, 0);
        add(0, 0, 1, 55, 0);
        run_table(0);

        // Asynchronous reset while the clock is low: outputs clear before any edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs(0, z, "async rst");
        @(posedge clk);
        #1;
        check_outputs(0, z, "rst held");
        @(negedge clk);
        rst = 1'b0;
        tbl.delete();
        add(0, 0, 1, 0, 0);
        add(1, 0, 1, 8, 0);
        add(0, 0, 1, 8, 0);
        run_table(0);

        // Wide instance: 31 FCTs reach the ceiling exactly, the 32nd overflows.
        tbl.delete();
        add(0, 0, 1, 0, 0);
        for (int k = 1; k <= 31; k++) begin
            add(1, 0, 1, 8 * k, 0);
            add(0, 0, 1, 8 * k, 0);
        end
        add(1, 0, 1, 248, ERR_EN);
        add(0, 0, 1, 248, ERR_EN);
        run_table(1);

        chk("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tx_credit_counter.md
# tx_credit_counter

Parametrised transmit flow-control credit counter for the SpaceWire TX path (ECSS-E-ST-50-12C). It accumulates credit from received FCTs and consumes one credit per N-Char sent. It detects credit overflow and exposes status flags to the TX scheduler. It sits between the RX FCT decoder (`gotfct_tx`) and the TX character encoder (`char_sent`), and replaces the fixed 6-bit/56-credit counter with configurable width, increment and ceiling.

## Interface
- `CREDIT_W`, 6: width of the credit counter.
- `FCT_INC`, 8: credits added per received FCT.
- `MAX_CREDIT`, 56: legal credit ceiling; must satisfy `MAX_CREDIT < 2**CREDIT_W` and `FCT_INC <= MAX_CREDIT`.

Ports:
- `pclk_tx`  in  1  TX clock; the single clock of the block.
- `reset_tx`  in  1  reset, asynchronous, active-high.
- `enable_tx`  in  1  link enable; low clears credit synchronously and holds the block idle.
- `gotfct_tx`  in  1  FCT received, level; each rising edge = one FCT.
- `char_sent`  in  1  N-Char transmitted, level; each rising edge = one credit consumed.
- `fct_counter_p`  out  CREDIT_W  current credit.
- `credit_avail`  out  1  `fct_counter_p != 0`.
- `credit_full`  out  1  `fct_counter_p + FCT_INC > MAX_CREDIT`; a further FCT would overflow.
- `credit_error`  out  1  sticky credit error (see Configuration).

## Operation
- States:
  - DISABLED (reset state).
  - RUN.
  - ERROR (exists only with `TX_CREDIT_ERROR_EN`).
- Transitions:
  - DISABLED→RUN when `enable_tx`=1.
  - RUN→ERROR on overflow.
  - Any state→DISABLED when `enable_tx`=0; this clears the count and `credit_error`.
  - ERROR holds until `enable_tx`=0 or reset.
- Edge detection: `inc = gotfct_tx & ~gotfct_q`, `dec = char_sent & ~char_q`. Each `_q` is the input registered every cycle, including while DISABLED. A level held high counts once.
- RUN update, computed in a CREDIT_W+1-bit intermediate:
  - inc only: `count + FCT_INC`.
  - dec only: `count - 1` if `count != 0`, else hold at 0. Underflow is ignored; no wrap.
  - inc and dec in the same cycle: `count + FCT_INC - 1`. If `count = 0`, the result is `FCT_INC`, not `FCT_INC - 1`.
  - neither: hold.
- Overflow condition: the computed result is greater than `MAX_CREDIT`.
- In DISABLED and ERROR, the count is frozen (DISABLED forces 0) and edges are discarded.
- `credit_avail` and `credit_full` are decoded from the registered count only. There is no combinational input→output path.

## Timing
- Reset values: `fct_counter_p`=0, `credit_avail`=0, `credit_full`=0 (valid because `FCT_INC <= MAX_CREDIT`), `credit_error`=0, state DISABLED, `gotfct_q`=`char_q`=0.
- Latency: an input rising edge sampled at clock edge N updates `fct_counter_p` and the flags after edge N. Visible 1 cycle after the input goes high.
- Minimum input spacing: 2 cycles (high, then low) per event. Faster toggling is undefined.
- `enable_tx` deassert: count is 0 after the next edge. `reset_tx` mid-operation: all outputs 0 immediately (asynchronous).
- `credit_error` rises in the same cycle the overflowing update would have been applied.

## Configuration
- `TX_CREDIT_ERROR_EN` defined:
  - Overflow moves the FSM to ERROR and asserts `credit_error` (sticky).
  - `fct_counter_p` keeps its pre-overflow value.
  - The link layer uses this to raise the ECSS credit error.
- `TX_CREDIT_ERROR_EN` undefined:
  - No ERROR state; `credit_error` is tied to 0.
  - Overflow saturates `fct_counter_p` at `MAX_CREDIT` and stays in RUN.

## Structure
- Shared package `tx_fc_pkg`:
  - state enum `tx_credit_state_t` (DISABLED, RUN, ERROR).
  - default constants `TX_CREDIT_W_DEF`=6, `TX_FCT_INC_DEF`=8, `TX_MAX_CREDIT_DEF`=56.
- One sub-module, `tx_fc_edge_det`: 1-bit rising-edge detector with async active-high reset. Instantiated twice, for `gotfct_tx` and `char_sent`.
- Parameter legality is checked by an elaboration-time assertion.

## Test plan
- Reset then `enable_tx`=1, seven `gotfct_tx` pulses: count 8,16,…,56 in steps of 8. `credit_full`=1 at 56 and at 49..56; `credit_avail`=1 from 8 onward.
- Count 56, eighth FCT:
  - with the macro: `credit_error`=1, count stays 56, later `char_sent` ignored.
  - without the macro: count stays 56, `credit_error`=0.
- Count 8, eight `char_sent` pulses → 0, `credit_avail`=0. A ninth pulse keeps 0, with no wrap to 63.
- Count 0, `gotfct_tx` and `char_sent` rise in the same cycle → 8. Count 16, same stimulus → 23.
- `gotfct_tx` held high 10 cycles → exactly +8. `enable_tx` dropped at count 40 → 0 after one edge, `credit_error` cleared. `reset_tx` pulse mid-count → outputs 0 asynchronously.
- Instantiate with `CREDIT_W`=8, `FCT_INC`=8, `MAX_CREDIT`=248: 31 FCTs → 248 with no error. The 32nd FCT triggers overflow handling per the macro.
